// File: rtl/adma_cm_xfer_cmpl.sv
// Transfer-completion collector: rising edges of per-descriptor done flags are
// queued and reported one at a time, round-robin, with an acknowledge clear pulse.
module adma_cm_xfer_cmpl #(
    parameter  int DMA_DESC_DEPTH = 4,
    localparam int IDX_W          = $clog2(DMA_DESC_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DMA_DESC_DEPTH-1:0] xfer_done_i,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_clear_o,
    input  logic                      irq_en_i,
    output logic                      irq_o,
    output logic                      cmpl_valid_o,
    input  logic                      cmpl_ready_i,
    output logic [IDX_W-1:0]          cmpl_idx_o,
    output logic [DMA_DESC_DEPTH-1:0] ovr_flag_o,
    input  logic [DMA_DESC_DEPTH-1:0] ovr_clear_i,
    output logic [IDX_W-1:0]          rr_ptr_o
);

    // Report port: a report transfers on any cycle with cmpl_valid_o & cmpl_ready_i;
    // once raised, cmpl_valid_o and cmpl_idx_o hold until that handshake.

    logic [DMA_DESC_DEPTH-1:0] done_q, pend_q, pend_d, ovr_q, ovr_d, clr_q, clr_d;
    logic [DMA_DESC_DEPTH-1:0] rise, load_vec;
    logic                      valid_q, valid_d, irq_q, irq_d;
    logic [IDX_W-1:0]          idx_q, idx_d, rr_q, rr_d, win_idx;
    logic                      win_found, slot_free, load, hs;
    int                        cand;

    assign rise      = xfer_done_i & ~done_q;
    assign slot_free = ~valid_q | cmpl_ready_i;
    assign hs        = valid_q & cmpl_ready_i;

    // First pending bit scanning from rr_q upward, wrapping at the depth.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < DMA_DESC_DEPTH; k++) begin
            cand = (int'(rr_q) + k) % DMA_DESC_DEPTH;
            if (!win_found && pend_q[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign load = slot_free & win_found;

    always_comb begin
        load_vec = '0;
        clr_d    = '0;
        for (int i = 0; i < DMA_DESC_DEPTH; i++) begin
            load_vec[i] = load & (win_idx == IDX_W'(i));
            clr_d[i]    = hs & (idx_q == IDX_W'(i));
        end
    end

    // A new rise beats the load of the same bit, so it is never an overrun.
    assign pend_d = rise | (pend_q & ~load_vec);
    assign ovr_d  = (ovr_q & ~ovr_clear_i) | (rise & pend_q & ~load_vec);

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = win_idx;
            if (win_idx == IDX_W'(DMA_DESC_DEPTH - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = win_idx + 1'b1;
            end
        end else if (cmpl_ready_i) begin
            valid_d = 1'b0;
        end
        irq_d = irq_en_i & valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            clr_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            rr_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            done_q  <= xfer_done_i;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            clr_q   <= clr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            irq_q   <= irq_d;
        end
    end

    assign xfer_done_clear_o = clr_q;
    assign irq_o             = irq_q;
    assign cmpl_valid_o      = valid_q;
    assign cmpl_idx_o        = idx_q;
    assign ovr_flag_o        = ovr_q;
    assign rr_ptr_o          = rr_q;

endmodule

// File: tb/tb_adma_cm_xfer_cmpl.sv
// Bench for adma_cm_xfer_cmpl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_adma_cm_xfer_cmpl;

    localparam int D = 4;
    localparam int W = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [D-1:0] xd, oclr, clr_o, ovr_o;
    logic         ien, rdy, irq_o, valid_o;
    logic [W-1:0] idx_o, rr_o;

    adma_cm_xfer_cmpl #(.DMA_DESC_DEPTH(D)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .xfer_done_i       (xd),
        .xfer_done_clear_o (clr_o),
        .irq_en_i          (ien),
        .irq_o             (irq_o),
        .cmpl_valid_o      (valid_o),
        .cmpl_ready_i      (rdy),
        .cmpl_idx_o        (idx_o),
        .ovr_flag_o        (ovr_o),
        .ovr_clear_i       (oclr),
        .rr_ptr_o          (rr_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // behavioural model: sets of pending/overrun descriptors, one report slot
    bit m_done[D], m_pend[D], m_ovr[D];
    bit m_valid, m_irq;
    int m_idx, m_rr, m_clr;
    logic [D-1:0] exp_q[$];

    function automatic logic [D-1:0] to_vec(input bit a[D]);
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic logic [D-1:0] one_hot(input int k);
        logic [D-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_done[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_valid = 0; m_irq = 0; m_idx = 0; m_rr = 0; m_clr = -1;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int  load;
        bit  rise;
        load = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < D; k++) begin
                if (load < 0 && m_pend[(m_rr + k) % D]) load = (m_rr + k) % D;
            end
        end
        m_clr = (m_valid && rdy) ? m_idx : -1;
        if (m_clr >= 0) exp_q.push_back(one_hot(m_clr));
        for (int i = 0; i < D; i++) begin
            rise = xd[i] && !m_done[i];
            if (rise && m_pend[i] && i != load) m_ovr[i] = 1;
            else if (oclr[i])                   m_ovr[i] = 0;
            m_pend[i] = rise || (m_pend[i] && i != load);
            m_done[i] = xd[i];
        end
        if (load >= 0) begin
            m_valid = 1; m_idx = load; m_rr = (load + 1) % D;
        end else if (rdy) begin
            m_valid = 0;
        end
        m_irq = ien && m_valid;
    endtask

    task automatic compare_all();
        check("valid", valid_o, m_valid);
        check("idx",   idx_o, m_idx);
        check("irq",   irq_o, m_irq);
        check("ovr",   ovr_o, to_vec(m_ovr));
        check("clr",   clr_o, one_hot(m_clr));
        check("rr",    rr_o, m_rr);
        if (clr_o != '0) begin
            if (exp_q.size() == 0) check("clr_sb_empty", clr_o, 0);
            else                   check("clr_sb", clr_o, exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", valid_o, 0);
        check("rst_irq",   irq_o, 0);
        check("rst_clr",   clr_o, 0);
        check("rst_ovr",   ovr_o, 0);
        check("rst_idx",   idx_o, 0);
        check("rst_rr",    rr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        xd = '0; oclr = '0; ien = 1'b1; rdy = 1'b0;
        do_reset();

        // single rise on descriptor 2
        step(); step();
        xd = 4'b0100;
        step(); step();
        check("t1_valid", valid_o, 1);
        check("t1_idx",   idx_o, 2);
        check("t1_irq",   irq_o, 1);
        rdy = 1'b1;
        step();
        check("t1_clr", clr_o, 4'b0100);
        xd = '0;
        step();
        check("t1_clr_end", clr_o, 0);

        // three bits at once drained back to back
        do_reset();
        xd = 4'b1011; rdy = 1'b1;
        step();
        step(); check("t2_idx0", idx_o, 0);
        step(); check("t2_idx1", idx_o, 1);
        step(); check("t2_idx3", idx_o, 3);
        check("t2_rr", rr_o, 0);
        xd = '0;
        step(); step();

        // round-robin continues after last winner
        do_reset();
        xd = 4'b0010; rdy = 1'b1;
        step(); step();
        check("t3_idx1", idx_o, 1);
        xd = 4'b0111;
        step();
        step(); check("t3_idx2", idx_o, 2);
        step(); check("t3_idx0", idx_o, 0);

        // overrun under backpressure, then hold, irq_en drop, overrun clear
        do_reset();
        rdy = 1'b0; xd = 4'b0001;
        step(); step();
        xd = 4'b1001; step();
        xd = 4'b0001; step();
        xd = 4'b1001; step();
        check("t4_ovr", ovr_o, 4'b1000);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_valid", valid_o, 1);
            check("t5_idx",   idx_o, 0);
            check("t5_clr",   clr_o, 0);
        end
        check("t5_irq_on", irq_o, 1);
        ien = 1'b0; oclr = 4'b1000;
        step();
        check("t5_irq_off", irq_o, 0);
        check("t4_ovr_clr", ovr_o, 0);
        oclr = '0; ien = 1'b1;

        // reset with report in flight and more pending
        xd = 4'b1111;
        step();
        xd = '0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            check("t6_no_rpt", valid_o, 0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(0, 4) == 0) xd[i] = ~xd[i];
                oclr[i] = ($urandom_range(0, 7) == 0);
            end
            rdy = ($urandom_range(0, 9) < 7);
            ien = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
